// File: rtl/keypad_pkg.sv
// Shared constants and enums for the matrix keypad scanner.
// Imported by the scanner top and its helpers.
package keypad_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 4;
  localparam int CODE_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } kp_state_t;

  typedef enum logic [1:0] {
    NONE,
    KEY,
    MULTI
  } frame_t;

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchroniser for the asynchronous row returns.
// Resets to all-ones so rows read as idle.
module kp_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/keypad_scanner.sv
// 5x4 matrix keypad scanner: column drive, frame evaluation,
// press/release debounce and a ready/read code handshake.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  input  logic                readn,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_ready,
  output logic                overrun
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DB_W   = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int COL_W  = $clog2(NUM_COLS);
  localparam int ROW_W  = $clog2(NUM_ROWS);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLS - 1);
  localparam logic [DB_W-1:0]   DB_TGT    = DB_W'(DEBOUNCE_FRAMES);

  logic [NUM_ROWS-1:0] w_rows;

  kp_sync #(.W(NUM_ROWS)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (row_in),
    .o_q  (w_rows)
  );

  logic [SLOT_W-1:0]   r_slot;
  logic [COL_W-1:0]    r_col;
  logic [NUM_COLS-1:0] r_col_out;
  logic [1:0]          r_nlow;
  logic [CODE_W-1:0]   r_fcode;

  logic                w_slot_end;
  logic                w_frame_end;
  logic [COL_W-1:0]    w_col_nx;
  logic [2:0]          w_cnt;
  logic [ROW_W-1:0]    w_row;
  logic [2:0]          w_sum;
  logic [1:0]          w_nlow_nx;
  logic [CODE_W-1:0]   w_code_nx;
  frame_t              w_frame;

  assign w_slot_end  = (r_slot == SLOT_LAST);
  assign w_frame_end = w_slot_end && (r_col == COL_LAST);
  assign w_col_nx    = w_frame_end ? '0 : r_col + COL_W'(1);

  always_comb begin
    w_cnt = '0;
    w_row = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!w_rows[r]) begin
        w_cnt = w_cnt + 3'd1;
        w_row = ROW_W'(r);
      end
    end
  end

  // Low-row total saturates at 2: anything above one is a ghost frame.
  assign w_sum     = {1'b0, r_nlow} + w_cnt;
  assign w_nlow_nx = (w_sum > 3'd1) ? 2'd2 : w_sum[1:0];
  assign w_code_nx = (w_cnt == 3'd1) ? {r_col, w_row} : r_fcode;

  always_comb begin
    w_frame = NONE;
    if (w_nlow_nx == 2'd1) w_frame = KEY;
    else if (w_nlow_nx == 2'd2) w_frame = MULTI;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_slot    <= '0;
      r_col     <= '0;
      r_col_out <= {{(NUM_COLS-1){1'b1}}, 1'b0};
      r_nlow    <= '0;
      r_fcode   <= '0;
    end else if (w_slot_end) begin
      r_slot    <= '0;
      r_col     <= w_col_nx;
      r_col_out <= ~(NUM_COLS'(1) << w_col_nx);
      r_nlow    <= w_frame_end ? 2'd0 : w_nlow_nx;
      r_fcode   <= w_frame_end ? '0 : w_code_nx;
    end else begin
      r_slot <= r_slot + SLOT_W'(1);
    end
  end

  kp_state_t         r_state;
  kp_state_t         w_state_nx;
  logic [CODE_W-1:0] r_cand;
  logic [CODE_W-1:0] w_cand_nx;
  logic [DB_W-1:0]   r_dbc;
  logic [DB_W-1:0]   w_dbc_nx;
  logic [DB_W-1:0]   w_dbc_inc;
  logic              w_accept;
  logic [CODE_W-1:0] w_acc_code;

  assign w_dbc_inc = r_dbc + DB_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cand  <= '0;
      r_dbc   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cand  <= w_cand_nx;
      r_dbc   <= w_dbc_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_dbc_nx   = r_dbc;
    w_accept   = 1'b0;
    w_acc_code = r_cand;
    if (w_frame_end) begin
      unique case (r_state)
        IDLE: begin
          if (w_frame == KEY) begin
            w_cand_nx = w_code_nx;
            if (DEBOUNCE_FRAMES == 1) begin
              w_accept   = 1'b1;
              w_acc_code = w_code_nx;
              w_state_nx = HELD;
            end else begin
              w_dbc_nx   = DB_W'(1);
              w_state_nx = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (w_frame != KEY) begin
            w_state_nx = IDLE;
          end else if (w_code_nx != r_cand) begin
            w_cand_nx = w_code_nx;
            w_dbc_nx  = DB_W'(1);
          end else if (w_dbc_inc == DB_TGT) begin
            w_accept   = 1'b1;
            w_state_nx = HELD;
          end else begin
            w_dbc_nx = w_dbc_inc;
          end
        end
        HELD: begin
          if (w_frame != KEY) begin
            if (DEBOUNCE_FRAMES == 1) begin
              w_state_nx = IDLE;
            end else begin
              w_dbc_nx   = DB_W'(1);
              w_state_nx = REL_DB;
            end
          end
        end
        REL_DB: begin
          if (w_frame == KEY) begin
            w_state_nx = HELD;
          end else if (w_dbc_inc == DB_TGT) begin
            w_state_nx = IDLE;
          end else begin
            w_dbc_nx = w_dbc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  logic [CODE_W-1:0] r_code;
  logic              r_ready;
  logic              r_ovr;
  logic              w_ack;

  assign w_ack = !readn && r_ready;

  // A fresh accept beats a same-cycle ack; overrun only when unacked.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_code  <= '0;
      r_ready <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_accept) begin
      r_code  <= w_acc_code;
      r_ready <= 1'b1;
      if (r_ready && readn) r_ovr <= 1'b1;
      else if (w_ack) r_ovr <= 1'b0;
    end else if (w_ack) begin
      r_ready <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign col_out   = r_col_out;
  assign key_code  = r_code;
  assign key_ready = r_ready;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboarded bench for keypad_scanner with a frame-level model.
// Stimulus holds one key pattern per whole scan frame.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DF = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       readn = 1'b1;
  logic [3:0] row_in;
  logic [4:0] col_out;
  logic [4:0] key_code;
  logic       key_ready;
  logic       overrun;

  logic [19:0] keys = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV        (SD),
    .DEBOUNCE_FRAMES (DF)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .row_in    (row_in),
    .col_out   (col_out),
    .readn     (readn),
    .key_code  (key_code),
    .key_ready (key_ready),
    .overrun   (overrun)
  );

  // Physical keypad: a pressed key pulls its row low when its column is driven.
  always_comb begin
    row_in = '1;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 4; r++)
        if (!col_out[c] && keys[c*4+r]) row_in[r] = 1'b0;
  end

  typedef struct {
    int code;
    bit ovr;
  } exp_t;

  exp_t exp_q[$];

  bit armed;
  int run_code;
  int run_len;
  bit exp_ready;
  bit exp_ovr;
  int exp_code;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int frame_result(input logic [19:0] m);
    if ($countones(m) != 1) return -1;
    for (int i = 0; i < 20; i++)
      if (m[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    armed     = 1'b1;
    run_code  = -2;
    run_len   = 0;
    exp_ready = 1'b0;
    exp_ovr   = 1'b0;
    exp_code  = 0;
  endtask

  logic       prev_ready = 1'b0;
  logic [4:0] prev_code = '0;

  always @(negedge clk) begin
    if (rstn) begin
      if ((key_ready && !prev_ready) || (key_code != prev_code)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept: got code %0d, expected none",
                   key_code);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("accept_code", int'(key_code), e.code);
          chk("accept_ovr", int'(overrun), int'(e.ovr));
        end
      end
    end
    prev_ready = key_ready;
    prev_code  = key_code;
  end

  // One full frame: starts just after a frame boundary, ends after the next.
  task automatic run_frame(input logic [19:0] m, input bit ack_mid_i,
                           input bit ack_end);
    int r;
    bit acc;
    bit ack_mid;
    bit rdy_mid;
    bit ovr_mid;
    int code_mid;
    ack_mid = ack_mid_i;
    keys = m;
    r = frame_result(m);
    if (r == run_code) run_len++;
    else begin
      run_code = r;
      run_len  = 1;
    end
    acc = 1'b0;
    if (armed && r >= 0 && run_len >= DF) begin
      acc   = 1'b1;
      armed = 1'b0;
    end else if (!armed && r < 0 && run_len >= DF) begin
      armed = 1'b1;
    end
    if (acc && exp_ready && r == exp_code) ack_mid = 1'b1;
    if (ack_mid && exp_ready) begin
      exp_ready = 1'b0;
      exp_ovr   = 1'b0;
    end
    rdy_mid  = exp_ready;
    ovr_mid  = exp_ovr;
    code_mid = exp_code;
    if (acc) begin
      if (exp_ready) exp_ovr = !ack_end;
      exp_ready = 1'b1;
      exp_code  = r;
      exp_q.push_back('{r, exp_ovr});
    end else if (ack_end && exp_ready) begin
      exp_ready = 1'b0;
      exp_ovr   = 1'b0;
    end
    repeat (9) @(posedge clk);
    @(negedge clk);
    readn = !ack_mid;
    @(posedge clk);
    @(negedge clk);
    readn = 1'b1;
    chk("mid_ready", int'(key_ready), int'(rdy_mid));
    chk("mid_ovr", int'(overrun), int'(ovr_mid));
    chk("mid_code", int'(key_code), code_mid);
    repeat (9) @(posedge clk);
    @(negedge clk);
    readn = !ack_end;
    @(posedge clk);
    @(negedge clk);
    readn = 1'b1;
    chk("end_ready", int'(key_ready), int'(exp_ready));
    chk("end_ovr", int'(overrun), int'(exp_ovr));
    chk("end_code", int'(key_code), exp_code);
    chk("col_wrap", int'(col_out), 5'b11110);
  endtask

  task automatic frames(input logic [19:0] m, input int n);
    for (int i = 0; i < n; i++) run_frame(m, 1'b0, 1'b0);
  endtask

  task automatic reset_mid(input logic [19:0] m);
    keys = m;
    repeat (9) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_ready", int'(key_ready), 0);
    chk("rst_code", int'(key_code), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_col", int'(col_out), 5'b11110);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  localparam logic [19:0] NOKEY = 20'd0;

  initial begin
    logic [19:0] m;
    int          kind;
    int          len;
    int          a;
    int          b;
    model_reset();
    repeat (3) @(negedge clk);
    chk("init_ready", int'(key_ready), 0);
    chk("init_code", int'(key_code), 0);
    chk("init_ovr", int'(overrun), 0);
    chk("init_col", int'(col_out), 5'b11110);
    rstn = 1'b1;

    // steady press of code 9, then one read
    frames(20'd1 << 9, 4);
    run_frame(20'd1 << 9, 1'b1, 1'b0);
    frames(NOKEY, 3);

    // bounce, plus a read strobe with nothing pending
    run_frame(20'd1 << 9, 1'b0, 1'b0);
    run_frame(NOKEY, 1'b1, 1'b0);
    frames(20'd1 << 9, 2);
    frames(NOKEY, 3);

    // ghost frames then single key 0
    frames((20'd1 << 0) | (20'd1 << 19), 6);
    frames(20'd1 << 0, 3);
    run_frame(20'd1 << 0, 1'b1, 1'b0);
    frames(NOKEY, 3);

    // overrun: 5 left unread, then 19
    frames(20'd1 << 5, 3);
    frames(NOKEY, 3);
    frames(20'd1 << 19, 3);
    frames(NOKEY, 2);
    run_frame(NOKEY, 1'b1, 1'b0);

    // accept of 7 coinciding with an ack of a pending 12
    frames(20'd1 << 12, 3);
    frames(NOKEY, 3);
    frames(20'd1 << 7, 2);
    run_frame(20'd1 << 7, 1'b0, 1'b1);
    run_frame(20'd1 << 7, 1'b1, 1'b0);
    frames(NOKEY, 3);

    // reset during press debounce and during hold
    run_frame(20'd1 << 3, 1'b0, 1'b0);
    reset_mid(20'd1 << 3);
    frames(20'd1 << 3, 4);
    reset_mid(20'd1 << 3);
    frames(20'd1 << 3, 3);
    run_frame(NOKEY, 1'b1, 1'b0);
    frames(NOKEY, 3);

    // randomized segments
    for (int s = 0; s < 16; s++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 5);
      a    = $urandom_range(0, 19);
      b    = (a + 1 + $urandom_range(0, 18)) % 20;
      m    = '0;
      if (kind >= 3) m[a] = 1'b1;
      if (kind == 9) m[b] = 1'b1;
      for (int f = 0; f < len; f++)
        run_frame(m, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0);
    end
    frames(NOKEY, 3);

    chk("pending_accepts", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Upstream neighbour of the 32-bit operand-entry stage.
- Drives a 5-column × 4-row matrix keypad, synchronises and debounces the row returns, and encodes one pressed key as a 5-bit code.
- Presents that code on a ready/read handshake, i.e. the `Din`/`D_ready`/`readn` trio the entry stage consumes.
- Ghosted (multi-key) frames are rejected. Unread codes overwritten by a new press are flagged.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column stays driven; ≥ 4.
- `DEBOUNCE_FRAMES`, default 4: consecutive identical full-keypad frames needed to accept a press or a release; ≥ 1.
- `clk`  in  1  system clock, rising-edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `row_in`  in  4  keypad rows, active-low, asynchronous to `clk`.
- `col_out`  out  5  keypad column drive, active-low, one-cold.
- `readn`  in  1  consumer read strobe; 0 = code taken this cycle.
- `key_code`  out  5  accepted key code, 0..19.
- `key_ready`  out  1  `key_code` valid and unread.
- `overrun`  out  1  sticky: an unread code was overwritten.

## Operation
- **Reset values**
  - `col_out` = 5'b11110 (column 0 driven).
  - `key_code` = 0, `key_ready` = 0, `overrun` = 0.
  - Column index 0, slot counter 0, FSM in IDLE, debounce count 0.
- **Synchronisation:** `row_in` passes through a 2-flop synchroniser.
- **Scan**
  - Column c is driven for `SCAN_DIV` cycles, then c+1. After column 4 it wraps to 0.
  - Rows are sampled on the last cycle of each column slot.
  - One frame = 5 slots.
- **Frame result** (evaluated at the end of column 4's slot)
  - NONE: no row low anywhere.
  - KEY(code): exactly one row low in exactly one column; code = col×4 + row.
  - MULTI: more than one low row in total. Treated as NONE.
- **FSM**
  - IDLE
    - KEY(k): candidate := k, count := 1, go to PRESS_DB.
    - If `DEBOUNCE_FRAMES` = 1, accept immediately instead.
  - PRESS_DB
    - KEY(same): count++. When count reaches `DEBOUNCE_FRAMES`, accept and go to HELD.
    - KEY(other): candidate := new code, count := 1, stay in PRESS_DB.
    - NONE: go to IDLE.
  - HELD
    - NONE: count := 1, go to REL_DB. If `DEBOUNCE_FRAMES` = 1, go straight to IDLE.
    - Any KEY: stay in HELD. No new accept until released.
  - REL_DB
    - NONE: count++. When count reaches `DEBOUNCE_FRAMES`, go to IDLE.
    - Any KEY: go to HELD.
- **Accept:** `key_code` := candidate, `key_ready` := 1. If `key_ready` was already 1 and is not being acked in that cycle, `overrun` := 1.
- **Handshake**
  - `key_ready` clears on the edge where `readn` = 0 and `key_ready` = 1.
  - `overrun` clears on that same edge.
  - `readn` = 0 while `key_ready` = 0 has no effect.
  - Accept and ack in the same cycle: accept wins. `key_ready` stays 1, `key_code` takes the new value, `overrun` is not set.
- **Stability:** `key_code` holds until the next accept and is never changed by an ack.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous). A press in progress is discarded and must re-debounce from IDLE.

## Timing
- Frame period: 5×`SCAN_DIV` cycles.
- Press latency: a key stable from before a frame start raises `key_ready` at the end of frame number `DEBOUNCE_FRAMES`, plus ≤ 2 synchroniser cycles of skew. Worst case ≤ (`DEBOUNCE_FRAMES`+1)×5×`SCAN_DIV` + 2 cycles.
- Outputs are registered. `key_ready` and `key_code` change on the same edge.
- `key_ready` falls on the clock edge that samples `readn` = 0 (visible the next cycle).
- `col_out` changes only on slot boundaries. It is never all-high or multi-low after reset.

## Structure
- **Package `keypad_pkg`:**
  - `NUM_COLS` = 5, `NUM_ROWS` = 4, `CODE_W` = 5.
  - FSM state enum: IDLE, PRESS_DB, HELD, REL_DB.
  - Frame-result enum: NONE, KEY, MULTI.
- **Sub-module `kp_sync`:** parameterised-width 2-flop synchroniser; reset to all-ones, i.e. rows idle.
- **Counter widths:** slot counter sized `$clog2(SCAN_DIV)`; debounce counter sized `$clog2(DEBOUNCE_FRAMES+1)`.

## Test plan
Bench uses `SCAN_DIV` = 4, `DEBOUNCE_FRAMES` = 3 (frame = 20 cycles).
- Hold key at col 2, row 1 steady for 5 frames → `key_ready` rises with `key_code` = 9 within 4 frames + 2 cycles. Pulse `readn` = 0 for one cycle → `key_ready` = 0 next cycle, `key_code` stays 9.
- Bounce: press for 1 frame, release 1 frame, press 2 frames, release → `key_ready` never rises.
- Ghost: hold col 0 row 0 and col 4 row 3 together for 6 frames → no accept. Release col 4 row 3 → accept `key_code` = 0 after 3 frames.
- Overrun: accept code 5, release and debounce, never ack, then press col 4 row 3 → `key_code` = 19, `overrun` = 1. One ack clears both flags.
- Simultaneous: hold `readn` = 0 on the exact accept cycle of code 7 → `key_ready` = 1, `key_code` = 7, `overrun` = 0.
- Assert `rstn` = 0 mid-PRESS_DB and mid-HELD → all outputs at reset values asynchronously. A key held through reset is re-accepted 3 frames after release of reset.
